paint_dispenser: RTL and testbench
==================================

Name: paint_dispenser

Overview:
- Actuator-side counterpart of the colour-loading sequencer.
- Accepts the one-hot motor enables (R, Y, B) and runs the selected pump motor until its programmed number of units has been dispensed.
- Returns per-channel completion flags that the sequencer consumes to advance R→Y→B.
- Sits between the sequencer and the motor driver pins; targets come from the keypad/digit entry path.

Parameters:
- CNT_W, 8, width of target amount and unit counter per channel.
- TICKS_PER_UNIT, 50000, clock cycles of motor run time per dispensed unit (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- motor_en  input  3  per-channel enable from the sequencer; bit2=R, bit1=Y, bit0=B; normally one-hot or zero.
- target_r  input  CNT_W  units to dispense on R; sampled in LOAD.
- target_y  input  CNT_W  units to dispense on Y; sampled in LOAD.
- target_b  input  CNT_W  units to dispense on B; sampled in LOAD.
- flags  output  3  per-channel done; same bit order as motor_en.
- motor_on  output  3  per-channel motor drive; same bit order.
- step  output  3  one-cycle pulse per completed unit; same bit order.
- busy  output  1  OR of all channels being in LOAD or RUN.

Behaviour:
- Reset (asynchronous, reset low): all channels go to IDLE; counters clear; flags, motor_on, step and busy are 0.
- Three independent identical channels. Each channel has:
  - FSM states IDLE, LOAD, RUN, DONE;
  - a timer of width clog2(TICKS_PER_UNIT);
  - a unit counter of width CNT_W;
  - a latched target of width CNT_W.
- IDLE:
  - en=1 → LOAD; else stay.
  - Outputs: flag=0, motor_on=0.
- LOAD (one cycle):
  - tgt ← target input; timer ← 0; units ← 0.
  - If target input = 0 → DONE; else → RUN.
  - motor_on=0.
  - If en=0 in this cycle → IDLE.
- RUN:
  - motor_on=1.
  - timer increments every cycle. At timer = TICKS_PER_UNIT-1: timer ← 0, units ← units+1, step=1 in that cycle.
  - If that tick makes units+1 = tgt → DONE.
  - en=0 in any RUN cycle → IDLE next cycle (abort): motor off, no flag, partial count discarded.
- DONE:
  - flag=1, motor_on=0; hold while en=1.
  - en=0 → IDLE next cycle. flag stays high for the cycle in which en falls, which is harmless because the sequencer moves to the next colour's flag.
- Timing:
  - motor_on rises 2 clock edges after en is first sampled high.
  - For a target of N ≥ 1, RUN lasts exactly N×TICKS_PER_UNIT cycles.
  - flag rises on the edge after the last step pulse.
- Output decode:
  - flags, motor_on and busy decode from registered state, so they are glitch-free.
  - step is decoded from registered state and timer.
- Target handling: target changes after LOAD are ignored; the latched tgt governs.
- Multiple enables high: each channel behaves independently, so several motors may run. This is not an error.
- Re-enable after DONE requires en to pass through 0. This guarantees one dispense per enable assertion.
- Counter widths:
  - Unit counter never wraps, because DONE is taken at tgt ≤ 2^CNT_W-1.
  - Timer wraps only via the explicit TICKS_PER_UNIT-1 compare.

Decomposition:
- Shared package holds:
  - channel index constants CH_R=2, CH_Y=1, CH_B=0 (shared with the sequencer);
  - the channel state encoding IDLE/LOAD/RUN/DONE.
- Natural sub-module: dispense_channel (one FSM, timer, unit counter), instantiated three times.
- Top level only does target muxing by index and the OR for busy.

Test Plan (TICKS_PER_UNIT=4, CNT_W=8):
- Reset release, motor_en=000 → flags, motor_on, step and busy all 0 for 20 cycles.
- target_r=3, motor_en=100 held:
  - motor_on[2] high for exactly 12 cycles;
  - step[2] pulses on RUN cycles 4, 8 and 12;
  - flags[2]=1 the next cycle and held until motor_en[2]=0, clearing one cycle after.
- target_y=0, motor_en=010 → flags[1]=1 two edges after enable; motor_on[1] and step[1] never assert.
- Full sequence R=2, Y=1, B=5, with enables switching 100→010→001 on the cycle after each flag → motor run lengths 8, 4 and 20 cycles in order, with no overlap.
- Abort: target_b=10, motor_en=001 dropped after 7 RUN cycles → motor_on[0]=0 next cycle, flags[0] never set; re-enable → full 40-cycle run.
- Reset asserted mid-RUN (async, between edges) → motor_on and busy drop immediately without a clock edge; after release, the channel stays IDLE while en=0.

Source files
------------

// File: rtl/paint_dispenser_pkg.sv
// paint_dispenser_pkg: channel indices and per-channel state encoding shared with the sequencer
package paint_dispenser_pkg;
  localparam int CH_R = 2;
  localparam int CH_Y = 1;
  localparam int CH_B = 0;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} ch_state_e;
endpackage

// File: rtl/paint_dispenser_dispense_channel.sv
// dispense_channel: one pump channel that runs its motor for target x TICKS_PER_UNIT cycles
module dispense_channel
  import paint_dispenser_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TICKS_PER_UNIT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] target,
  output logic             flag,
  output logic             motor_on,
  output logic             step,
  output logic             busy
);
  localparam int TW = $clog2(TICKS_PER_UNIT);
  ch_state_e        state, next_state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] units, tgt;
  logic             tick;
  assign tick = timer == TW'(TICKS_PER_UNIT - 1);
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  // next state: dropping en always returns to IDLE, which also discards a partial run
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = en ? LOAD : IDLE;
      LOAD: next_state = !en ? IDLE : (target == '0 ? DONE : RUN);
      RUN:  next_state = !en ? IDLE : (tick && CNT_W'(units + 1'b1) == tgt ? DONE : RUN);
      DONE: next_state = en ? DONE : IDLE;
      default: next_state = IDLE;
    endcase
  end
  // target latch, unit timer and unit counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      timer <= '0;
      units <= '0;
      tgt   <= '0;
    end else if (state == LOAD) begin
      timer <= '0;
      units <= '0;
      tgt   <= target;
    end else if (state == RUN) begin
      timer <= tick ? '0 : timer + 1'b1;
      units <= units + CNT_W'(tick);
    end
  // outputs decoded from registered state and timer
  always_comb begin
    flag     = state == DONE;
    motor_on = state == RUN;
    step     = state == RUN && tick;
    busy     = state == LOAD || state == RUN;
  end
endmodule

// File: rtl/paint_dispenser.sv
// paint_dispenser: three independent pump channels driven by the sequencer's one-hot enables
module paint_dispenser
  import paint_dispenser_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TICKS_PER_UNIT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       motor_en,
  input  logic [CNT_W-1:0] target_r,
  input  logic [CNT_W-1:0] target_y,
  input  logic [CNT_W-1:0] target_b,
  output logic [2:0]       flags,
  output logic [2:0]       motor_on,
  output logic [2:0]       step,
  output logic             busy
);
  logic [CNT_W-1:0] tgt [3];
  logic [2:0]       ch_busy;
  assign tgt[CH_R] = target_r;
  assign tgt[CH_Y] = target_y;
  assign tgt[CH_B] = target_b;
  assign busy = |ch_busy;
  for (genvar i = 0; i < 3; i++) begin : g_ch
    dispense_channel #(
      .CNT_W(CNT_W),
      .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .en(motor_en[i]),
      .target(tgt[i]),
      .flag(flags[i]),
      .motor_on(motor_on[i]),
      .step(step[i]),
      .busy(ch_busy[i])
    );
  end
endmodule

// File: tb/tb_paint_dispenser.sv
// tb_paint_dispenser: random and directed stimulus checked against an enable-age model
module tb_paint_dispenser;
  localparam int W = 8;
  localparam int T = 4;
  logic         clk = 0, reset = 0;
  logic [2:0]   motor_en = 0;
  logic [W-1:0] target_r = 0, target_y = 0, target_b = 0;
  logic [2:0]   flags, motor_on, step;
  logic         busy;
  int n_pass = 0, n_chk = 0;
  int k [3];
  int mt [3];

  always #5 clk = ~clk;

  paint_dispenser #(.CNT_W(W), .TICKS_PER_UNIT(T)) dut (
    .clk(clk), .reset(reset), .motor_en(motor_en),
    .target_r(target_r), .target_y(target_y), .target_b(target_b),
    .flags(flags), .motor_on(motor_on), .step(step), .busy(busy)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int tin(int i);
    return i == 2 ? int'(target_r) : i == 1 ? int'(target_y) : int'(target_b);
  endfunction

  // k = number of consecutive edges at which the enable was sampled high;
  // the target is taken at the second such edge
  always @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 3; i++) k[i] = 0;
    else for (int i = 0; i < 3; i++)
      if (motor_en[i]) begin
        k[i]++;
        if (k[i] == 2) mt[i] = tin(i);
      end else k[i] = 0;

  function automatic bit m_run(int i);
    return k[i] >= 2 && mt[i] > 0 && k[i] <= mt[i] * T + 1;
  endfunction
  function automatic bit m_flag(int i);
    return k[i] >= 2 && (mt[i] == 0 || k[i] >= mt[i] * T + 2);
  endfunction
  function automatic bit m_step(int i);
    return m_run(i) && (k[i] - 1) % T == 0;
  endfunction

  always @(negedge clk) begin
    logic [2:0] ef, eo, es;
    logic eb;
    eb = 0;
    for (int i = 0; i < 3; i++) begin
      ef[i] = m_flag(i);
      eo[i] = m_run(i);
      es[i] = m_step(i);
      eb = eb | k[i] == 1 | m_run(i);
    end
    chk("flags", 32'(flags), 32'(ef));
    chk("motor_on", 32'(motor_on), 32'(eo));
    chk("step", 32'(step), 32'(es));
    chk("busy", 32'(busy), 32'(eb));
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // runs channel ch (already enabled) until its flag, returning motor_on cycle count
  task automatic run_until_flag(int ch, output int on, output int overlap);
    on = 0;
    overlap = 0;
    for (int c = 0; c < 400; c++) begin
      cyc(1);
      if (motor_on[ch]) on++;
      if ($countones(motor_on) > 1) overlap++;
      if (flags[ch]) return;
    end
    on = -1;
  endtask

  initial begin
    int bad, on, ov, last_step, fc;
    int steps[$];
    cyc(3);
    reset = 1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if ({flags, motor_on, step, busy} != 0) bad++;
    end
    chk("idle20", bad, 0);

    target_r = 3;
    motor_en = 3'b100;
    on = 0; last_step = -1; fc = -1;
    for (int c = 0; c < 40 && fc < 0; c++) begin
      cyc(1);
      if (motor_on[2]) begin
        on++;
        if (step[2]) begin
          steps.push_back(on);
          last_step = c;
        end
      end
      if (flags[2]) fc = c;
    end
    chk("r_on_len", on, 12);
    chk("r_nsteps", steps.size(), 3);
    if (steps.size() == 3) begin
      chk("r_step0", steps[0], 4);
      chk("r_step1", steps[1], 8);
      chk("r_step2", steps[2], 12);
    end
    chk("r_flag_lat", fc - last_step, 1);
    target_r = 9;
    cyc(3);
    chk("r_flag_hold", 32'(flags[2]), 1);
    chk("r_no_rerun", 32'(motor_on[2]), 0);
    motor_en = 0;
    chk("r_flag_fall_cycle", 32'(flags[2]), 1);
    cyc(1);
    chk("r_flag_clr", 32'(flags[2]), 0);

    target_y = 0;
    motor_en = 3'b010;
    cyc(1);
    chk("y0_load", 32'({flags[1], motor_on[1]}), 0);
    cyc(1);
    chk("y0_flag", 32'(flags[1]), 1);
    chk("y0_motor", 32'(motor_on[1]), 0);
    motor_en = 0;
    cyc(2);

    target_r = 2; target_y = 1; target_b = 5;
    motor_en = 3'b100;
    run_until_flag(2, on, ov);
    chk("seq_r_len", on, 8);
    motor_en = 3'b010;
    run_until_flag(1, on, bad);
    chk("seq_y_len", on, 4);
    ov += bad;
    motor_en = 3'b001;
    run_until_flag(0, on, bad);
    chk("seq_b_len", on, 20);
    chk("seq_overlap", ov + bad, 0);
    motor_en = 0;
    cyc(2);

    target_b = 10;
    motor_en = 3'b001;
    on = 0;
    for (int c = 0; c < 40 && on < 7; c++) begin
      cyc(1);
      if (motor_on[0]) on++;
    end
    motor_en = 0;
    cyc(1);
    chk("abort_motor", 32'(motor_on[0]), 0);
    chk("abort_flag", 32'(flags[0]), 0);
    cyc(2);
    motor_en = 3'b001;
    run_until_flag(0, on, ov);
    chk("rerun_len", on, 40);
    motor_en = 0;
    cyc(2);

    target_r = 5;
    motor_en = 3'b100;
    cyc(4);
    chk("pre_rst_motor", 32'(motor_on[2]), 1);
    #2 reset = 0;
    #1;
    chk("async_motor", 32'(motor_on), 0);
    chk("async_busy", 32'(busy), 0);
    motor_en = 0;
    cyc(2);
    reset = 1;
    cyc(5);
    chk("post_rst_idle", 32'({flags, motor_on, busy}), 0);

    for (int c = 0; c < 4000; c++) begin
      cyc(1);
      if ($urandom_range(0, 19) == 0) motor_en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) target_r = W'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) target_y = W'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) target_b = W'($urandom_range(0, 6));
    end
    motor_en = 0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
